plic_target_arbiter: RTL and testbench
======================================

// Module: plic_target_arbiter
// PURPOSE
//  PLIC core for one hart target. Latches requests from the PLIC gateway into pending bits.
//  Holds per-source priority, enable and threshold registers.
//  Selects the highest-priority eligible source with a sequential scan and drives the hart's external-interrupt line.
//  Serves claim and complete from the CSR/MMIO side. Returns completion notifications to the gateway so it re-arms the source.
// PARAMETERS
//  INTERRUPTS     8   number of live sources (1..31). Gateway bit i maps to source ID i+1.
//  PRIORITY_BITS  5   priority/threshold width. 0 = never interrupt.
// PORTS
//  clk                         in   1   clock
//  rst                         in   1   reset, synchronous, active-high
//  interrupt_request           in   32  gateway requests; bit i = source ID i+1
//  cfg_we                      in   1   config write strobe
//  cfg_addr                    in   6   1..INTERRUPTS=priority[ID]; 0x20=enable mask; 0x21=threshold
//  cfg_wdata                   in   32  write data; priority/threshold use [PRIORITY_BITS-1:0]; enable bit i = ID i+1
//  claim_req                   in   1   claim pulse from hart
//  claim_valid                 out  1   claim response strobe, 1 cycle
//  claim_id                    out  32  claimed ID; 0 = none
//  complete_valid              in   1   completion write from hart
//  complete_id                 in   32  ID being completed
//  interrupt_completion_notif  out  1   1-cycle pulse to gateway
//  interrupt_completion_ID     out  32  ID to gateway, valid with notif
//  eip                         out  1   external interrupt pending to hart
// BEHAVIOUR
//  Reset values
//   - All outputs, pending, priorities, enable and threshold = 0.
//   - Scan index = 1; best_id = best_prio = 0; committed max_id = max_prio = 0.
//  Pending register
//   - Cycle after interrupt_request[i]=1 (i<INTERRUPTS): pending[i]=1. Bits >= INTERRUPTS are ignored.
//   - A claim of ID i+1 clears pending[i]. If a request and a claim on the same source arrive in the same cycle, the claim clear wins.
//  Scan FSM
//   - States: SCAN and COMMIT. Index runs 1..INTERRUPTS, one source per cycle.
//   - In SCAN, a source is a candidate if pending & enable & priority > best_prio, with strict >. Ties therefore resolve to the lowest ID.
//   - At index INTERRUPTS the FSM enters COMMIT for 1 cycle: max_id/max_prio <= best, best <= 0, index <= 1, back to SCAN.
//   - Period = INTERRUPTS+1 cycles.
//   - Config writes take effect on the source's next scan visit.
//  eip (registered)
//   - eip = (max_id!=0) & pending[max_id-1] & enable[max_id-1] & (max_prio > threshold).
//   - Worst-case latency from request to eip = 1 + 2*(INTERRUPTS+1) cycles.
//  Claim
//   - claim_req -> next cycle claim_valid=1 and claim_id = max_id if the eip condition holds at the request cycle, else 0.
//   - A nonzero claim clears pending and forces max_id/max_prio=0 until the next COMMIT. This prevents a double claim and drops eip the cycle after the claim.
//   - Back-to-back claims are allowed; the second returns 0 unless a COMMIT has occurred in between.
//  Complete
//   - complete_valid with 1 <= complete_id <= INTERRUPTS -> next cycle notif=1 and interrupt_completion_ID=complete_id, for exactly 1 cycle.
//   - Out-of-range IDs (including 0) are silently ignored.
//   - Claim and complete in the same cycle are both serviced independently.
//  Config
//   - Writes to unmapped addresses, or to priority IDs > INTERRUPTS, are ignored.
//   - Lowering the threshold or enabling a source never asserts eip combinationally. It takes effect at the next eip register update, i.e. 1 cycle.
//  Reset mid-operation
//   - Reset during SCAN, claim or complete restores all reset values.
//   - Any in-flight claim/complete response is dropped. The scan restarts at ID 1 on the first cycle after rst deasserts.
// TESTING
//  1. prio[3]=2, enable=0xFF, thr=0; pulse request bit 2 -> eip=1 within 19 cycles; claim -> claim_id=3, eip=0 next cycle.
//  2. Srcs 2 and 5 with equal priority 4 both pending -> claim_id=2. Next claim after COMMIT -> 5. Third claim -> 0.
//  3. prio[1]=3, thr=3, src 1 pending -> eip stays 0. Write thr=2 -> eip=1 by the next COMMIT+1.
//  4. complete_id=4 -> notif 1-cycle pulse, ID=4. complete_id=0 and complete_id=9 -> no notif.
//  5. Request on ID 6 and claim of ID 6 in the same cycle -> pending[5]=0. Claim plus complete in the same cycle -> both responses seen.
//  6. Assert rst mid-scan with eip=1 -> all outputs 0 next cycle; pending cleared; scan index=1.

Source files
------------

// File: rtl/plic_target_arbiter_if.sv
// Bus bundle between a hart/gateway pair and the PLIC target arbiter.
// The master side drives requests, config, claim and complete; the slave side is the arbiter.
interface plic_target_arbiter_if;
    logic [31:0] interrupt_request;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        claim_req;
    logic        claim_valid;
    logic [31:0] claim_id;
    logic        complete_valid;
    logic [31:0] complete_id;
    logic        interrupt_completion_notif;
    logic [31:0] interrupt_completion_ID;
    logic        eip;

    modport master (
        output interrupt_request, cfg_we, cfg_addr, cfg_wdata,
               claim_req, complete_valid, complete_id,
        input  claim_valid, claim_id, interrupt_completion_notif,
               interrupt_completion_ID, eip
    );

    modport slave (
        input  interrupt_request, cfg_we, cfg_addr, cfg_wdata,
               claim_req, complete_valid, complete_id,
        output claim_valid, claim_id, interrupt_completion_notif,
               interrupt_completion_ID, eip
    );
endinterface

// File: rtl/plic_target_arbiter.sv
// PLIC core for one hart: pending latch, priority/enable/threshold registers,
// sequential highest-priority scan, claim/complete service and the eip line.
module plic_target_arbiter #(
    parameter int INTERRUPTS    = 8,
    parameter int PRIORITY_BITS = 5
) (
    input logic clk,
    input logic rst,
    plic_target_arbiter_if.slave bus
);

    typedef enum logic {SCAN, COMMIT} state_t;

    state_t                   state, state_next;
    logic [5:0]               idx, idx_next;
    logic [5:0]               best_id, best_id_next, max_id;
    logic [PRIORITY_BITS-1:0] best_prio, best_prio_next, max_prio;
    logic [PRIORITY_BITS-1:0] threshold, scan_prio;
    logic [PRIORITY_BITS-1:0] prio [INTERRUPTS];
    logic [INTERRUPTS-1:0]    pending, enable, claim_clear;
    logic                     scan_hit, max_pend, max_en, eip_cond, claim_hit;
    logic                     complete_ok;
    logic                     unused_bits;

    assign unused_bits = ^{bus.interrupt_request, bus.cfg_wdata};

    assign complete_ok = bus.complete_valid && (bus.complete_id >= 32'd1) &&
                         (bus.complete_id <= 32'(INTERRUPTS));

    // Look up the source under the scan index and the committed winner.
    always_comb begin
        scan_prio   = '0;
        scan_hit    = 1'b0;
        max_pend    = 1'b0;
        max_en      = 1'b0;
        claim_clear = '0;
        for (int i = 0; i < INTERRUPTS; i++) begin
            if (idx == 6'(i + 1)) begin
                scan_prio = prio[i];
                scan_hit  = pending[i] & enable[i];
            end
            if (max_id == 6'(i + 1)) begin
                max_pend = pending[i];
                max_en   = enable[i];
            end
        end
        eip_cond  = (max_id != 6'd0) && max_pend && max_en && (max_prio > threshold);
        claim_hit = bus.claim_req && eip_cond;
        for (int i = 0; i < INTERRUPTS; i++) begin
            if (claim_hit && (max_id == 6'(i + 1)))
                claim_clear[i] = 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        best_id_next   = best_id;
        best_prio_next = best_prio;
        case (state)
            SCAN: begin
                // Strict > keeps the lowest ID on equal priority.
                if (scan_hit && (scan_prio > best_prio)) begin
                    best_id_next   = idx;
                    best_prio_next = scan_prio;
                end
                if (idx == 6'(INTERRUPTS))
                    state_next = COMMIT;
                else
                    idx_next = idx + 6'd1;
            end
            COMMIT: begin
                best_id_next   = 6'd0;
                best_prio_next = '0;
                idx_next       = 6'd1;
                state_next     = SCAN;
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= SCAN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx                            <= 6'd1;
            best_id                        <= 6'd0;
            best_prio                      <= '0;
            max_id                         <= 6'd0;
            max_prio                       <= '0;
            pending                        <= '0;
            enable                         <= '0;
            threshold                      <= '0;
            for (int i = 0; i < INTERRUPTS; i++) prio[i] <= '0;
            bus.claim_valid                <= 1'b0;
            bus.claim_id                   <= '0;
            bus.interrupt_completion_notif <= 1'b0;
            bus.interrupt_completion_ID    <= '0;
            bus.eip                        <= 1'b0;
        end else begin
            idx       <= idx_next;
            best_id   <= best_id_next;
            best_prio <= best_prio_next;
            // A claim blanks the winner until the next commit, even a coincident one.
            if (claim_hit) begin
                max_id   <= 6'd0;
                max_prio <= '0;
            end else if (state == COMMIT) begin
                max_id   <= best_id;
                max_prio <= best_prio;
            end
            pending <= (pending | bus.interrupt_request[INTERRUPTS-1:0]) & ~claim_clear;
            if (bus.cfg_we) begin
                for (int i = 0; i < INTERRUPTS; i++)
                    if (bus.cfg_addr == 6'(i + 1)) prio[i] <= bus.cfg_wdata[PRIORITY_BITS-1:0];
                if (bus.cfg_addr == 6'h20) enable    <= bus.cfg_wdata[INTERRUPTS-1:0];
                if (bus.cfg_addr == 6'h21) threshold <= bus.cfg_wdata[PRIORITY_BITS-1:0];
            end
            bus.claim_valid                <= bus.claim_req;
            bus.claim_id                   <= claim_hit ? 32'(max_id) : 32'd0;
            bus.interrupt_completion_notif <= complete_ok;
            bus.interrupt_completion_ID    <= complete_ok ? bus.complete_id : 32'd0;
            // Registered eip falls together with the claim response.
            bus.eip                        <= eip_cond & ~claim_hit;
        end
    end

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Directed bench for plic_target_arbiter with 8 sources and 5-bit priorities.
module tb_plic_target_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    plic_target_arbiter_if bus ();

    plic_target_arbiter #(.INTERRUPTS(8), .PRIORITY_BITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse_request(input logic [31:0] mask);
        bus.interrupt_request = mask;
        tick();
        bus.interrupt_request = '0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_eip(input int budget);
        int waited;
        waited = 0;
        while (!bus.eip && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.eip !== 1'b0) begin errors++; $display("[TB] FAIL reset_eip: got %0b want 0", bus.eip); end
        checks++;
        if (bus.claim_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_claim_valid: got %0b want 0", bus.claim_valid); end
        checks++;
        if (bus.claim_id !== 32'd0) begin errors++; $display("[TB] FAIL reset_claim_id: got %0d want 0", bus.claim_id); end
        checks++;
        if (bus.interrupt_completion_notif !== 1'b0) begin errors++; $display("[TB] FAIL reset_notif: got %0b want 0", bus.interrupt_completion_notif); end
        checks++;
        if (bus.interrupt_completion_ID !== 32'd0) begin errors++; $display("[TB] FAIL reset_notif_id: got %0d want 0", bus.interrupt_completion_ID); end
    endtask

    task automatic test_single_source();
        cfg_write(6'd3, 32'd2);
        cfg_write(6'h20, 32'hFF);
        cfg_write(6'h21, 32'd0);
        pulse_request(32'h4);
        wait_eip(19);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL single_eip_latency: got %0b want 1", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_valid !== 1'b1 || bus.claim_id !== 32'd3) begin
            errors++; $display("[TB] FAIL single_claim: got valid %0b id %0d want valid 1 id 3", bus.claim_valid, bus.claim_id);
        end
        tick();
        checks++;
        if (bus.eip !== 1'b0 || bus.claim_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_after_claim: got eip %0b valid %0b want 0 0", bus.eip, bus.claim_valid);
        end
        wait_cycles(20);
        checks++;
        if (bus.eip !== 1'b0) begin errors++; $display("[TB] FAIL single_pending_cleared: got eip %0b want 0", bus.eip); end
    endtask

    task automatic test_tie_order();
        cfg_write(6'd2, 32'd4);
        cfg_write(6'd5, 32'd4);
        pulse_request(32'h12);
        wait_cycles(20);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL tie_eip: got %0b want 1", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 32'd2) begin errors++; $display("[TB] FAIL tie_first_claim: got %0d want 2", bus.claim_id); end
        tick();
        wait_eip(40);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL tie_second_eip: got %0b want 1", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        checks++;
        if (bus.claim_valid !== 1'b1 || bus.claim_id !== 32'd5) begin
            errors++; $display("[TB] FAIL tie_second_claim: got valid %0b id %0d want valid 1 id 5", bus.claim_valid, bus.claim_id);
        end
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_valid !== 1'b1 || bus.claim_id !== 32'd0) begin
            errors++; $display("[TB] FAIL tie_back_to_back: got valid %0b id %0d want valid 1 id 0", bus.claim_valid, bus.claim_id);
        end
    endtask

    task automatic test_threshold();
        cfg_write(6'd1, 32'd3);
        cfg_write(6'h21, 32'd3);
        pulse_request(32'h1);
        wait_cycles(20);
        checks++;
        if (bus.eip !== 1'b0) begin errors++; $display("[TB] FAIL thr_masked_eip: got %0b want 0", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_valid !== 1'b1 || bus.claim_id !== 32'd0) begin
            errors++; $display("[TB] FAIL thr_masked_claim: got valid %0b id %0d want valid 1 id 0", bus.claim_valid, bus.claim_id);
        end
        cfg_write(6'h21, 32'd2);
        wait_eip(10);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL thr_lowered_eip: got %0b want 1", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 32'd1) begin errors++; $display("[TB] FAIL thr_claim: got %0d want 1", bus.claim_id); end
        cfg_write(6'h21, 32'd0);
    endtask

    task automatic test_complete();
        bus.complete_valid = 1'b1;
        bus.complete_id    = 32'd4;
        tick();
        bus.complete_valid = 1'b0;
        checks++;
        if (bus.interrupt_completion_notif !== 1'b1 || bus.interrupt_completion_ID !== 32'd4) begin
            errors++; $display("[TB] FAIL complete_4: got notif %0b id %0d want 1 4", bus.interrupt_completion_notif, bus.interrupt_completion_ID);
        end
        tick();
        checks++;
        if (bus.interrupt_completion_notif !== 1'b0) begin errors++; $display("[TB] FAIL complete_pulse_width: got %0b want 0", bus.interrupt_completion_notif); end
        bus.complete_valid = 1'b1;
        bus.complete_id    = 32'd0;
        tick();
        checks++;
        if (bus.interrupt_completion_notif !== 1'b0) begin errors++; $display("[TB] FAIL complete_id0: got %0b want 0", bus.interrupt_completion_notif); end
        bus.complete_id = 32'd9;
        tick();
        checks++;
        if (bus.interrupt_completion_notif !== 1'b0) begin errors++; $display("[TB] FAIL complete_id9: got %0b want 0", bus.interrupt_completion_notif); end
        bus.complete_id = 32'd8;
        tick();
        bus.complete_valid = 1'b0;
        checks++;
        if (bus.interrupt_completion_notif !== 1'b1 || bus.interrupt_completion_ID !== 32'd8) begin
            errors++; $display("[TB] FAIL complete_8: got notif %0b id %0d want 1 8", bus.interrupt_completion_notif, bus.interrupt_completion_ID);
        end
    endtask

    task automatic test_same_cycle();
        cfg_write(6'd6, 32'd5);
        pulse_request(32'h20);
        wait_eip(20);
        bus.claim_req         = 1'b1;
        bus.interrupt_request = 32'h20;
        tick();
        bus.claim_req         = 1'b0;
        bus.interrupt_request = '0;
        checks++;
        if (bus.claim_id !== 32'd6) begin errors++; $display("[TB] FAIL req_claim_id: got %0d want 6", bus.claim_id); end
        wait_cycles(20);
        checks++;
        if (bus.eip !== 1'b0) begin errors++; $display("[TB] FAIL req_claim_clear_wins: got eip %0b want 0", bus.eip); end
        pulse_request(32'h20);
        wait_eip(20);
        bus.claim_req      = 1'b1;
        bus.complete_valid = 1'b1;
        bus.complete_id    = 32'd6;
        tick();
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        checks++;
        if (bus.claim_valid !== 1'b1 || bus.claim_id !== 32'd6 ||
            bus.interrupt_completion_notif !== 1'b1 || bus.interrupt_completion_ID !== 32'd6) begin
            errors++;
            $display("[TB] FAIL claim_and_complete: got claim %0b/%0d notif %0b/%0d want 1/6 1/6",
                     bus.claim_valid, bus.claim_id, bus.interrupt_completion_notif, bus.interrupt_completion_ID);
        end
    endtask

    task automatic test_reset_mid();
        pulse_request(32'h2);
        wait_eip(20);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_eip: got %0b want 1", bus.eip); end
        rst                = 1'b1;
        bus.claim_req      = 1'b1;
        bus.complete_valid = 1'b1;
        bus.complete_id    = 32'd2;
        tick();
        bus.claim_req      = 1'b0;
        bus.complete_valid = 1'b0;
        rst                = 1'b0;
        checks++;
        if (bus.eip !== 1'b0 || bus.claim_valid !== 1'b0 || bus.claim_id !== 32'd0 ||
            bus.interrupt_completion_notif !== 1'b0 || bus.interrupt_completion_ID !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got eip %0b claim %0b/%0d notif %0b/%0d want all 0",
                     bus.eip, bus.claim_valid, bus.claim_id, bus.interrupt_completion_notif, bus.interrupt_completion_ID);
        end
        cfg_write(6'd2, 32'd4);
        cfg_write(6'h20, 32'hFF);
        wait_cycles(20);
        checks++;
        if (bus.eip !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pending_cleared: got eip %0b want 0", bus.eip); end
        pulse_request(32'h2);
        wait_eip(19);
        checks++;
        if (bus.eip !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_rescan_eip: got %0b want 1", bus.eip); end
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
        checks++;
        if (bus.claim_id !== 32'd2) begin errors++; $display("[TB] FAIL rstmid_claim: got %0d want 2", bus.claim_id); end
    endtask

    initial begin
        bus.interrupt_request = '0;
        bus.cfg_we            = 1'b0;
        bus.cfg_addr          = '0;
        bus.cfg_wdata         = '0;
        bus.claim_req         = 1'b0;
        bus.complete_valid    = 1'b0;
        bus.complete_id       = '0;
        rst                   = 1'b1;
        wait_cycles(3);
        test_reset();
        rst = 1'b0;
        tick();
        test_single_source();
        test_tie_order();
        test_threshold();
        test_complete();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
